// File: rtl/mac_pipe_sgn.sv
// Pipelined signed/unsigned multiply-accumulate with valid/ready handshake,
// framed accumulation (acc_first/acc_last) and optional saturation.
module mac_pipe_sgn #(
    parameter int WIDTH1 = 8,
    parameter int WIDTH2 = 8,
    parameter int ACC_W  = 24,
    parameter int PIPE   = 2,
    parameter int SAT    = 1
) (
    input  logic              sys_clk,
    input  logic              sys_rst_n,
    input  logic              en,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [WIDTH1-1:0] A,
    input  logic [WIDTH2-1:0] B,
    input  logic              signed_mode,
    input  logic              acc_first,
    input  logic              acc_last,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [ACC_W-1:0]  acc_out,
    output logic              overflow
);

    localparam int PW = PIPE * ACC_W;

    generate
        if (ACC_W < WIDTH1 + WIDTH2 || WIDTH1 < 2 || WIDTH2 < 2 || PIPE < 1) begin : g_param_chk
            $error("mac_pipe_sgn: illegal parameters (need ACC_W >= WIDTH1+WIDTH2, widths >= 2, PIPE >= 1)");
        end
    endgenerate

    logic              rdy_q;
    logic              stall, adv, accept;

    logic              s0_v, s0_sm, s0_f, s0_l;
    logic [WIDTH1-1:0] s0_a;
    logic [WIDTH2-1:0] s0_b;

    logic [ACC_W-1:0]  ext_a, ext_b, prod_c;

    logic [PIPE-1:0][ACC_W-1:0] p_q;
    logic [PIPE-1:0]   pv_q, psm_q, pf_q, pl_q;

    logic [ACC_W-1:0]  acc_q, pp, sat_val, acc_nxt;
    logic [ACC_W:0]    sum;
    logic              ovf_q, add_ovf, ovf_nxt, p_sm, p_v, p_f, p_l;

    assign stall    = out_valid & ~out_ready;
    assign adv      = en & ~stall;
    assign in_ready = rdy_q & adv;
    assign accept   = in_valid & in_ready;

    // in_ready stays low while reset is asserted and for the first edge after release
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) rdy_q <= 1'b0;
        else            rdy_q <= 1'b1;
    end

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            s0_v  <= 1'b0;
            s0_sm <= 1'b0;
            s0_f  <= 1'b0;
            s0_l  <= 1'b0;
            s0_a  <= '0;
            s0_b  <= '0;
        end else if (adv) begin
            s0_v <= accept;
            if (accept) begin
                s0_a  <= A;
                s0_b  <= B;
                s0_sm <= signed_mode;
                s0_f  <= acc_first;
                s0_l  <= acc_last;
            end
        end
    end

    // Low ACC_W bits of the extended-operand product equal the exact product in either mode
    always_comb begin
        ext_a  = {{(ACC_W-WIDTH1){s0_sm & s0_a[WIDTH1-1]}}, s0_a};
        ext_b  = {{(ACC_W-WIDTH2){s0_sm & s0_b[WIDTH2-1]}}, s0_b};
        prod_c = ext_a * ext_b;
    end

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            p_q   <= '0;
            pv_q  <= '0;
            psm_q <= '0;
            pf_q  <= '0;
            pl_q  <= '0;
        end else if (adv) begin
            p_q   <= PW'({p_q, prod_c});
            pv_q  <= PIPE'({pv_q, s0_v});
            psm_q <= PIPE'({psm_q, s0_sm});
            pf_q  <= PIPE'({pf_q, s0_f});
            pl_q  <= PIPE'({pl_q, s0_l});
        end
    end

    always_comb begin
        pp   = p_q[PIPE-1];
        p_v  = pv_q[PIPE-1];
        p_sm = psm_q[PIPE-1];
        p_f  = pf_q[PIPE-1];
        p_l  = pl_q[PIPE-1];
        sum  = {1'b0, acc_q} + {1'b0, pp};
        if (p_sm) begin
            add_ovf = (acc_q[ACC_W-1] == pp[ACC_W-1]) && (sum[ACC_W-1] != acc_q[ACC_W-1]);
            sat_val = acc_q[ACC_W-1] ? {1'b1, {(ACC_W-1){1'b0}}} : {1'b0, {(ACC_W-1){1'b1}}};
        end else begin
            add_ovf = sum[ACC_W];
            sat_val = '1;
        end
        if (p_f) begin
            acc_nxt = pp;
            ovf_nxt = 1'b0;
        end else begin
            acc_nxt = (add_ovf && SAT != 0) ? sat_val : sum[ACC_W-1:0];
            ovf_nxt = ovf_q | add_ovf;
        end
    end

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            acc_q     <= '0;
            ovf_q     <= 1'b0;
            acc_out   <= '0;
            overflow  <= 1'b0;
            out_valid <= 1'b0;
        end else begin
            if (adv && p_v) begin
                acc_q <= acc_nxt;
                ovf_q <= ovf_nxt;
                if (p_l) begin
                    acc_out  <= acc_nxt;
                    overflow <= ovf_nxt;
                end
            end
            // a pending result still drains while en=0
            if (adv && p_v && p_l) out_valid <= 1'b1;
            else if (out_ready)    out_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_mac_pipe_sgn.sv
// Directed bench for mac_pipe_sgn: a 24-bit saturating instance plus 16-bit
// saturating and wrapping instances sharing the same input stream.
module tb_mac_pipe_sgn;

    logic        sys_clk = 1'b0;
    logic        sys_rst_n = 1'b0;
    logic        en = 1'b1;
    logic        in_valid = 1'b0;
    logic [7:0]  A = '0;
    logic [7:0]  B = '0;
    logic        signed_mode = 1'b0;
    logic        acc_first = 1'b0;
    logic        acc_last = 1'b0;
    logic        out_ready = 1'b1;

    logic        rdy24, rdy16s, rdy16w;
    logic        v24, v16s, v16w;
    logic [23:0] acc24;
    logic [15:0] acc16s, acc16w;
    logic        o24, o16s, o16w;

    int errors = 0;
    int checks = 0;

    always #5 sys_clk = ~sys_clk;

    mac_pipe_sgn #(.WIDTH1(8), .WIDTH2(8), .ACC_W(24), .PIPE(2), .SAT(1)) u24 (
        .sys_clk(sys_clk), .sys_rst_n(sys_rst_n), .en(en), .in_valid(in_valid), .in_ready(rdy24),
        .A(A), .B(B), .signed_mode(signed_mode), .acc_first(acc_first), .acc_last(acc_last),
        .out_valid(v24), .out_ready(out_ready), .acc_out(acc24), .overflow(o24));

    mac_pipe_sgn #(.WIDTH1(8), .WIDTH2(8), .ACC_W(16), .PIPE(2), .SAT(1)) u16s (
        .sys_clk(sys_clk), .sys_rst_n(sys_rst_n), .en(en), .in_valid(in_valid), .in_ready(rdy16s),
        .A(A), .B(B), .signed_mode(signed_mode), .acc_first(acc_first), .acc_last(acc_last),
        .out_valid(v16s), .out_ready(out_ready), .acc_out(acc16s), .overflow(o16s));

    mac_pipe_sgn #(.WIDTH1(8), .WIDTH2(8), .ACC_W(16), .PIPE(2), .SAT(0)) u16w (
        .sys_clk(sys_clk), .sys_rst_n(sys_rst_n), .en(en), .in_valid(in_valid), .in_ready(rdy16w),
        .A(A), .B(B), .signed_mode(signed_mode), .acc_first(acc_first), .acc_last(acc_last),
        .out_valid(v16w), .out_ready(out_ready), .acc_out(acc16w), .overflow(o16w));

    typedef struct packed {
        logic [23:0] acc;
        logic        ovf;
    } res_t;

    res_t q24[$];
    res_t q16s[$];
    res_t q16w[$];

    // a result is taken when out_valid & out_ready hold across the coming edge
    always @(negedge sys_clk) begin
        if (sys_rst_n && out_ready) begin
            if (v24)  q24.push_back('{acc24, o24});
            if (v16s) q16s.push_back('{{8'h00, acc16s}, o16s});
            if (v16w) q16w.push_back('{{8'h00, acc16w}, o16w});
        end
    end

    typedef struct {
        logic [7:0]  a;
        logic [7:0]  b;
        logic        sm;
        logic        f;
        logic        l;
        logic [23:0] e24;
        logic [15:0] e16s;
        logic [15:0] e16w;
        logic        ov24;
        logic        ov16s;
        logic        ov16w;
    } vec_t;

    vec_t vecs[16];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
        end
    endtask

    task automatic send(input logic [7:0] a, input logic [7:0] b, input logic sm,
                        input logic f, input logic l);
        int n;
        A = a; B = b; signed_mode = sm; acc_first = f; acc_last = l;
        in_valid = 1'b1;
        n = 0;
        while (!rdy24 && n < 100) begin
            @(posedge sys_clk); #1;
            n++;
        end
        if (!rdy24) chk("send_timeout", 32'(n), 32'd0);
        @(posedge sys_clk); #1;
        in_valid = 1'b0;
    endtask

    task automatic wait_results(input int cnt);
        int n;
        n = 0;
        while (q24.size() < cnt && n < 200) begin
            @(posedge sys_clk); #1;
            n++;
        end
        chk("result_count", 32'(q24.size()), 32'(cnt));
    endtask

    task automatic lat_count(output int n);
        n = 0;
        while (!v24 && n < 30) begin
            @(posedge sys_clk); #1;
            n++;
        end
    endtask

    initial begin
        int k, n, sz;
        res_t r;

        //          a      b      sm    f     l     e24         e16s      e16w     ov24  ov16s ov16w
        vecs[0]  = '{8'hFF, 8'hFF, 1'b0, 1'b1, 1'b0, 24'h0,      16'h0,    16'h0,    1'b0, 1'b0, 1'b0};
        vecs[1]  = '{8'hFF, 8'hFF, 1'b0, 1'b0, 1'b0, 24'h0,      16'h0,    16'h0,    1'b0, 1'b0, 1'b0};
        vecs[2]  = '{8'h01, 8'h01, 1'b0, 1'b0, 1'b1, 24'd130051, 16'hFFFF, 16'hFC03, 1'b0, 1'b1, 1'b1};
        vecs[3]  = '{8'h80, 8'h80, 1'b1, 1'b1, 1'b0, 24'h0,      16'h0,    16'h0,    1'b0, 1'b0, 1'b0};
        vecs[4]  = '{8'h80, 8'h7F, 1'b1, 1'b0, 1'b1, 24'h000080, 16'h0080, 16'h0080, 1'b0, 1'b0, 1'b0};
        vecs[5]  = '{8'hFF, 8'hFF, 1'b0, 1'b1, 1'b0, 24'h0,      16'h0,    16'h0,    1'b0, 1'b0, 1'b0};
        vecs[6]  = '{8'hFF, 8'hFF, 1'b0, 1'b0, 1'b1, 24'd130050, 16'hFFFF, 16'hFC02, 1'b0, 1'b1, 1'b1};
        vecs[7]  = '{8'h80, 8'h7F, 1'b1, 1'b1, 1'b0, 24'h0,      16'h0,    16'h0,    1'b0, 1'b0, 1'b0};
        vecs[8]  = '{8'h80, 8'h7F, 1'b1, 1'b0, 1'b0, 24'h0,      16'h0,    16'h0,    1'b0, 1'b0, 1'b0};
        vecs[9]  = '{8'h80, 8'h7F, 1'b1, 1'b0, 1'b1, 24'hFF4180, 16'h8000, 16'h4180, 1'b0, 1'b1, 1'b1};
        vecs[10] = '{8'h80, 8'h80, 1'b1, 1'b1, 1'b0, 24'h0,      16'h0,    16'h0,    1'b0, 1'b0, 1'b0};
        vecs[11] = '{8'h80, 8'h80, 1'b1, 1'b0, 1'b1, 24'h008000, 16'h7FFF, 16'h8000, 1'b0, 1'b1, 1'b1};
        vecs[12] = '{8'hFF, 8'hFF, 1'b0, 1'b1, 1'b0, 24'h0,      16'h0,    16'h0,    1'b0, 1'b0, 1'b0};
        vecs[13] = '{8'hFF, 8'h01, 1'b1, 1'b0, 1'b1, 24'h00FE00, 16'hFE00, 16'hFE00, 1'b0, 1'b0, 1'b0};
        vecs[14] = '{8'hFD, 8'h07, 1'b1, 1'b1, 1'b1, 24'hFFFFEB, 16'hFFEB, 16'hFFEB, 1'b0, 1'b0, 1'b0};
        vecs[15] = '{8'h02, 8'h03, 1'b0, 1'b0, 1'b1, 24'hFFFFF1, 16'hFFF1, 16'hFFF1, 1'b0, 1'b0, 1'b0};

        // reset state
        #12;
        chk("rst_in_ready", {29'd0, rdy24, rdy16s, rdy16w}, 32'd0);
        chk("rst_out_valid", {29'd0, v24, v16s, v16w}, 32'd0);
        chk("rst_acc_out", 32'(acc24), 32'd0);
        chk("rst_overflow", {29'd0, o24, o16s, o16w}, 32'd0);
        @(negedge sys_clk) sys_rst_n = 1'b1;
        @(posedge sys_clk); #1;

        // first-beat latency: out_valid three edges after the accepting edge
        send(8'd5, 8'd4, 1'b0, 1'b1, 1'b1);
        lat_count(n);
        chk("latency", 32'(n), 32'd3);
        chk("latency_val", 32'(acc24), 32'd20);
        wait_results(1);
        q24.delete(); q16s.delete(); q16w.delete();

        // table, back to back
        for (int i = 0; i < 16; i++)
            send(vecs[i].a, vecs[i].b, vecs[i].sm, vecs[i].f, vecs[i].l);
        wait_results(8);
        k = 0;
        for (int i = 0; i < 16; i++) begin
            if (vecs[i].l) begin
                r = (k < q24.size()) ? q24[k] : '0;
                chk($sformatf("v%0d_acc24", i), 32'(r.acc), 32'(vecs[i].e24));
                chk($sformatf("v%0d_ovf24", i), 32'(r.ovf), 32'(vecs[i].ov24));
                r = (k < q16s.size()) ? q16s[k] : '0;
                chk($sformatf("v%0d_acc16s", i), 32'(r.acc), 32'(vecs[i].e16s));
                chk($sformatf("v%0d_ovf16s", i), 32'(r.ovf), 32'(vecs[i].ov16s));
                r = (k < q16w.size()) ? q16w[k] : '0;
                chk($sformatf("v%0d_acc16w", i), 32'(r.acc), 32'(vecs[i].e16w));
                chk($sformatf("v%0d_ovf16w", i), 32'(r.ovf), 32'(vecs[i].ov16w));
                k++;
            end
        end
        q24.delete(); q16s.delete(); q16w.delete();

        // backpressure: sink stalls for 5 cycles with more beats queued behind
        out_ready = 1'b0;
        fork
            begin
                send(8'd1, 8'd2, 1'b0, 1'b1, 1'b1);
                send(8'd3, 8'd4, 1'b0, 1'b1, 1'b1);
                send(8'd5, 8'd6, 1'b0, 1'b1, 1'b1);
            end
            begin
                lat_count(n);
                chk("bp_wait_valid", {31'd0, v24}, 32'd1);
                repeat (5) begin
                    @(posedge sys_clk); #2;
                    chk("bp_in_ready", {31'd0, rdy24}, 32'd0);
                    chk("bp_out_valid", {31'd0, v24}, 32'd1);
                    chk("bp_acc_hold", 32'(acc24), 32'd2);
                end
                out_ready = 1'b1;
            end
        join
        wait_results(3);
        chk("bp_res0", 32'(q24[0].acc), 32'd2);
        chk("bp_res1", 32'(q24[1].acc), 32'd12);
        chk("bp_res2", 32'(q24[2].acc), 32'd30);
        repeat (3) @(posedge sys_clk);
        #1;
        chk("bp_no_extra", 32'(q24.size()), 32'd3);
        q24.delete(); q16s.delete(); q16w.delete();

        // en gap with the frame in flight: same value as without the gap
        send(8'hFF, 8'hFF, 1'b0, 1'b1, 1'b0);
        send(8'hFF, 8'hFF, 1'b0, 1'b0, 1'b0);
        en = 1'b0;
        repeat (3) begin
            @(posedge sys_clk); #1;
            chk("en0_in_ready", {31'd0, rdy24}, 32'd0);
        end
        en = 1'b1;
        send(8'h01, 8'h01, 1'b0, 1'b0, 1'b1);
        wait_results(1);
        chk("en_gap_acc24", 32'(q24[0].acc), 32'd130051);
        chk("en_gap_ovf24", 32'(q24[0].ovf), 32'd0);
        chk("en_gap_acc16s", 32'(q16s[0].acc), 32'hFFFF);
        q24.delete(); q16s.delete(); q16w.delete();

        // en gap right after a single-beat frame delays it by exactly 3 cycles
        send(8'hFD, 8'h07, 1'b1, 1'b1, 1'b1);
        en = 1'b0;
        n = 0;
        repeat (3) begin
            @(posedge sys_clk); #1;
            n++;
        end
        chk("en_gap_no_valid", {31'd0, v24}, 32'd0);
        en = 1'b1;
        while (!v24 && n < 30) begin
            @(posedge sys_clk); #1;
            n++;
        end
        chk("en_gap_latency", 32'(n), 32'd6);
        chk("en_gap_fl_acc", 32'(acc24), 32'hFFFFEB);
        chk("en_gap_fl_ovf", {31'd0, o24}, 32'd0);
        wait_results(1);
        q24.delete(); q16s.delete(); q16w.delete();

        // reuse a saturated frame so the 16-bit overflow flag is set before reset
        send(8'hFF, 8'hFF, 1'b0, 1'b1, 1'b0);
        send(8'hFF, 8'hFF, 1'b0, 1'b0, 1'b1);
        wait_results(1);
        repeat (2) @(posedge sys_clk);
        #1;
        q24.delete(); q16s.delete(); q16w.delete();

        // asynchronous reset with two beats in flight
        send(8'd1, 8'd1, 1'b0, 1'b1, 1'b0);
        send(8'd2, 8'd2, 1'b0, 1'b0, 1'b1);
        #2 sys_rst_n = 1'b0;
        #1;
        chk("arst_out_valid", {29'd0, v24, v16s, v16w}, 32'd0);
        chk("arst_acc24", 32'(acc24), 32'd0);
        chk("arst_acc16s", 32'(acc16s), 32'd0);
        chk("arst_overflow", {29'd0, o24, o16s, o16w}, 32'd0);
        chk("arst_in_ready", {29'd0, rdy24, rdy16s, rdy16w}, 32'd0);
        sz = q24.size();
        @(negedge sys_clk);
        @(negedge sys_clk) sys_rst_n = 1'b1;
        repeat (10) @(posedge sys_clk);
        #1;
        chk("arst_no_result", 32'(q24.size() - sz), 32'd0);
        chk("arst_valid_low", {31'd0, v24}, 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, errors=%0d checks=%0d", errors, checks);
        $fatal(1, "watchdog");
    end

endmodule
